// File: rtl/ixc_assign_pipe.sv
// Elastic R->L word pipe: DEPTH valid/ready register stages, or a plain assign when DEPTH=0.
// Latency DEPTH cycles at 1 word/cycle; stalls backpressure to r_ready. Option: IXC_ASSIGN_PIPE_PARITY_EN.
module ixc_assign_pipe #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2,
  parameter int OCC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] R,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] L,
  output logic             l_valid,
  input  logic             l_ready,
  output logic [OCC_W-1:0] occ,
  output logic             par_err
);

  generate
    if (DEPTH == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign L       = R;
      assign l_valid = r_valid;
      assign r_ready = l_ready;
      assign occ     = '0;
      assign par_err = 1'b0;
    end else begin : g_pipe
      logic [WIDTH-1:0] d    [DEPTH];
      logic [WIDTH-1:0] up_d [DEPTH];
      logic [DEPTH-1:0] v, up_v, adv, ld;
      logic [OCC_W-1:0] occ_q;
      logic             in_x, out_x;

      always_comb begin
        up_v    = '0;
        up_v[0] = r_valid;
        up_d[0] = R;
        for (int k = 1; k < DEPTH; k++) begin
          up_v[k] = v[k-1];
          up_d[k] = d[k-1];
        end
      end

      // adv[k]: stage k's word moves on this cycle; a stage loads when empty or advancing.
      always_comb begin
        adv          = '0;
        adv[DEPTH-1] = l_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
          adv[k] = ~v[k+1] | adv[k+1];
        end
        ld = ~v | adv;
      end

      assign r_ready = ld[0];
      assign l_valid = v[DEPTH-1];
      assign L       = d[DEPTH-1];
      assign in_x    = r_valid & ld[0];
      assign out_x   = v[DEPTH-1] & l_ready;
      assign occ     = occ_q;

      // Data only moves with a valid word so an empty output keeps its last value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v     <= '0;
          occ_q <= '0;
          for (int k = 0; k < DEPTH; k++) d[k] <= '0;
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (ld[k]) begin
              v[k] <= up_v[k];
              if (up_v[k]) d[k] <= up_d[k];
            end
          end
          case ({in_x, out_x})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
          endcase
        end
      end

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
      logic [DEPTH-1:0] p, up_p;
      logic             perr_q;

      always_comb begin
        up_p    = '0;
        up_p[0] = ^R;
        for (int k = 1; k < DEPTH; k++) up_p[k] = p[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p      <= '0;
          perr_q <= 1'b0;
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (ld[k] && up_v[k]) p[k] <= up_p[k];
          end
          if (out_x && ((^d[DEPTH-1]) != p[DEPTH-1])) perr_q <= 1'b1;
        end
      end

      assign par_err = perr_q;
`else
      assign par_err = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed bench for ixc_assign_pipe: DEPTH=2 instance with a queue scoreboard, plus a DEPTH=0 instance.
module tb_ixc_assign_pipe;
  localparam int W = 34;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] R, L;
  logic         r_valid, r_ready, l_valid, l_ready, par_err;
  logic [3:0]   occ;

  logic [W-1:0] R0, L0;
  logic         rv0, rr0, lv0, lr0, pe0;
  logic [3:0]   occ0;

  int n_cmp = 0, n_bad = 0;
  int n_in, n_out, n_rr_low;
  logic xin, xout;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  ixc_assign_pipe #(.WIDTH(W), .DEPTH(2), .OCC_W(4)) dut (
    .clk(clk), .rst(rst), .R(R), .r_valid(r_valid), .r_ready(r_ready),
    .L(L), .l_valid(l_valid), .l_ready(l_ready), .occ(occ), .par_err(par_err));

  ixc_assign_pipe #(.WIDTH(W), .DEPTH(0), .OCC_W(4)) dut0 (
    .clk(clk), .rst(rst), .R(R0), .r_valid(rv0), .r_ready(rr0),
    .L(L0), .l_valid(lv0), .l_ready(lr0), .occ(occ0), .par_err(pe0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, update the model, return just after the edge.
  task automatic tick();
    @(negedge clk);
    xin  = r_valid && r_ready;
    xout = l_valid && l_ready;
    chk("occ_model", 64'(occ), 64'(q.size()));
    if (!r_ready) n_rr_low++;
    if (xout) begin
      n_out++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out: L=%0h with nothing in flight", L);
      end else begin
        chk("data_order", 64'(L), 64'(q.pop_front()));
      end
    end
    if (xin) begin
      q.push_back(R);
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, cyc, first, last;
    rst = 1'b1; R = '0; r_valid = 1'b0; l_ready = 1'b0;
    R0 = '0; rv0 = 1'b0; lr0 = 1'b0;
    n_in = 0; n_out = 0; n_rr_low = 0;

    // Reset state
    #3;
    chk("rst_l_valid", 64'(l_valid), 0);
    chk("rst_occ", 64'(occ), 0);
    chk("rst_L", 64'(L), 0);
    chk("rst_par_err", 64'(par_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rst_r_ready", 64'(r_ready), 1);

    // Single word latency
    R = 34'h2_DEAD_BEEF; r_valid = 1'b1; l_ready = 1'b1;
    #1 chk("t1_rr", 64'(r_ready), 1);
    chk("t1_occ0", 64'(occ), 0);
    tick();
    r_valid = 1'b0; R = '0;
    #1 chk("t1_occ1", 64'(occ), 1);
    chk("t1_lv_c1", 64'(l_valid), 0);
    tick();
    #1 chk("t1_lv_c2", 64'(l_valid), 1);
    chk("t1_L", 64'(L), 64'h2_DEAD_BEEF);
    chk("t1_occ2", 64'(occ), 1);
    tick();
    #1 chk("t1_occ3", 64'(occ), 0);
    chk("t1_lv_c3", 64'(l_valid), 0);
    chk("t1_L_hold", 64'(L), 64'h2_DEAD_BEEF);

    // Back-to-back stream 0..99
    n_in = 0; n_out = 0; n_rr_low = 0; nxt = 0; cyc = 0; first = -1; last = -1;
    while (n_out < 100 && cyc < 300) begin
      r_valid = (nxt < 100);
      R = W'(nxt);
      tick();
      if (xin) nxt++;
      if (xout) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
    end
    r_valid = 1'b0;
    chk("t2_count", 64'(n_out), 100);
    chk("t2_no_gap", 64'(last - first), 99);
    chk("t2_rr_low", 64'(n_rr_low), 0);

    // Backpressure: fill, hold third word, release
    l_ready = 1'b0; r_valid = 1'b1;
    R = 34'h100; tick();
    R = 34'h101; tick();
    R = 34'h102;
    #1 chk("t3_rr_full", 64'(r_ready), 0);
    chk("t3_occ", 64'(occ), 2);
    chk("t3_L", 64'(L), 64'h100);
    tick();
    chk("t3_held", 64'(xin), 0);
    l_ready = 1'b1;
    #1 chk("t3_rr_open", 64'(r_ready), 1);
    tick();
    chk("t3_acc3", 64'(xin), 1);
    r_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_empty", 64'(q.size()), 0);

    // Full pipe, simultaneous in/out
    l_ready = 1'b0; r_valid = 1'b1;
    R = 34'h200; tick();
    R = 34'h201; tick();
    n_in = 0; n_out = 0; l_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      R = W'(34'h202 + i);
      tick();
    end
    chk("t4_in", 64'(n_in), 10);
    chk("t4_out", 64'(n_out), 10);
    chk("t4_occ", 64'(occ), 2);
    r_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-stream
    l_ready = 1'b0; r_valid = 1'b1;
    R = 34'h300; tick();
    R = 34'h301; tick();
    r_valid = 1'b0;
    #1 chk("t5_pre_occ", 64'(occ), 2);
    #1 rst = 1'b1;
    #1 chk("t5_lv", 64'(l_valid), 0);
    chk("t5_occ", 64'(occ), 0);
    chk("t5_L", 64'(L), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    l_ready = 1'b1; R = 34'h3_1234_5678; r_valid = 1'b1;
    tick();
    r_valid = 1'b0;
    #1 chk("t5_lv_c1", 64'(l_valid), 0);
    tick();
    #1 chk("t5_lv_c2", 64'(l_valid), 1);
    chk("t5_L_after", 64'(L), 64'h3_1234_5678);
    tick();

    // DEPTH=0 pass-through
    for (int i = 0; i < 20; i++) begin
      R0  = {W'($urandom), 2'($urandom_range(3))} ^ W'($urandom);
      rv0 = 1'($urandom_range(1));
      lr0 = 1'($urandom_range(1));
      #1;
      chk("d0_L", 64'(L0), 64'(R0));
      chk("d0_lv", 64'(lv0), 64'(rv0));
      chk("d0_rr", 64'(rr0), 64'(lr0));
      chk("d0_occ", 64'(occ0), 0);
      @(posedge clk); #1;
    end

`ifdef IXC_ASSIGN_PIPE_PARITY_EN
    l_ready = 1'b0; R = 34'h55; r_valid = 1'b1;
    tick();
    r_valid = 1'b0;
    tick();
    q.delete();
    force dut.g_pipe.d[1] = 34'h75;
    #1 chk("t7_pre", 64'(par_err), 0);
    l_ready = 1'b1;
    @(posedge clk); #1;
    release dut.g_pipe.d[1];
    chk("t7_set", 64'(par_err), 1);
    @(posedge clk); #1;
    chk("t7_sticky", 64'(par_err), 1);
    rst = 1'b1;
    #1 chk("t7_clr", 64'(par_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
`else
    chk("par_err_tied", 64'(par_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
